// File: rtl/vslc_scan_ctrl_if.sv
// Bundles the VSLC scan controller's load stream, code-memory write port,
// core handshake and field I/O so the controller and its neighbours share one port.
interface vslc_scan_ctrl_if #(
    parameter int PROG_AW = 8,
    parameter int TMR_W   = 16
);
    logic               load_mode;
    logic               ld_valid;
    logic [3:0]         ld_nibble;
    logic               ld_ready;
    logic               mem_we;
    logic [PROG_AW-1:0] mem_addr;
    logic [3:0]         mem_wdata;
    logic [PROG_AW:0]   prog_len;
    logic [TMR_W-1:0]   scan_period;
    logic               core_start;
    logic               core_done;
    logic [7:0]         in_pins;
    logic [7:0]         in_snap;
    logic [7:0]         core_out;
    logic [7:0]         out_pins;
    logic [7:0]         scan_cnt;
    logic               overrun;
    logic               fault;
    logic [1:0]         state;

    // Environment side: loader, core and field wiring.
    modport master (
        output load_mode, ld_valid, ld_nibble, scan_period, core_done, in_pins, core_out,
        input  ld_ready, mem_we, mem_addr, mem_wdata, prog_len, core_start,
               in_snap, out_pins, scan_cnt, overrun, fault, state
    );

    // Controller side.
    modport slave (
        input  load_mode, ld_valid, ld_nibble, scan_period, core_done, in_pins, core_out,
        output ld_ready, mem_we, mem_addr, mem_wdata, prog_len, core_start,
               in_snap, out_pins, scan_cnt, overrun, fault, state
    );
endinterface

// File: rtl/vslc_scan_ctrl.sv
// vslc_scan_ctrl: loads the VSLC core's nibble code memory and sequences
// fixed-period scans with input snapshot, atomic output commit, period-overrun
// flag and a watchdog that forces outputs safe.
//
// state | meaning
// IDLE  | no scan active; waits for a load request or a runnable program
// LOAD  | accepting code nibbles into the code memory
// RUN   | core executing; scan timer and watchdog running
// WAIT  | outputs committed; holding until the next scan period begins
module vslc_scan_ctrl #(
    parameter int PROG_AW  = 8,
    parameter int TMR_W    = 16,
    parameter int WDOG_CYC = 1024
) (
    input logic             clk,
    input logic             rst_n,
    vslc_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] TMR_MAX   = '1;
    localparam logic [TMR_W-1:0] WDOG_LAST = TMR_W'(WDOG_CYC - 1);

    state_t             st;
    logic [PROG_AW:0]   wr_ptr;
    logic [PROG_AW:0]   prog_len_q;
    logic [TMR_W-1:0]   timer;
    logic               core_start_q;
    logic [7:0]         in_snap_q;
    logic [7:0]         out_pins_q;
    logic [7:0]         scan_cnt_q;
    logic               overrun_q;
    logic               fault_q;

    logic               ld_ready_c;
    logic               accept;
    logic [TMR_W-1:0]   timer_next;
    logic               period_reached;
    logic               period_overrun;
    logic               wdog_hit;

    // The top pointer bit set means the code memory is full, so stop accepting.
    assign ld_ready_c = (st == ST_LOAD) && !wr_ptr[PROG_AW];
    assign accept     = ld_ready_c && bus.ld_valid;

    // Scan timer saturates rather than wrapping so a long WAIT never looks early.
    assign timer_next     = (timer == TMR_MAX) ? timer : timer + TMR_W'(1);
    // The next scan starts on the edge where timer reaches period-1, giving exact spacing.
    assign period_reached = (bus.scan_period == '0) || (timer >= bus.scan_period - TMR_W'(1));
    assign period_overrun = (bus.scan_period != '0) && (timer >= bus.scan_period);
    assign wdog_hit       = (timer == WDOG_LAST);

    assign bus.ld_ready   = ld_ready_c;
    assign bus.mem_we     = accept;
    assign bus.mem_addr   = wr_ptr[PROG_AW-1:0];
    assign bus.mem_wdata  = bus.ld_nibble;
    assign bus.prog_len   = prog_len_q;
    assign bus.core_start = core_start_q;
    assign bus.in_snap    = in_snap_q;
    assign bus.out_pins   = out_pins_q;
    assign bus.scan_cnt   = scan_cnt_q;
    assign bus.overrun    = overrun_q;
    assign bus.fault      = fault_q;
    assign bus.state      = st;

    // Scan sequencer: state, load pointer, timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st           <= ST_IDLE;
            wr_ptr       <= '0;
            prog_len_q   <= '0;
            timer        <= '0;
            core_start_q <= 1'b0;
            in_snap_q    <= '0;
            out_pins_q   <= '0;
            scan_cnt_q   <= '0;
            overrun_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (bus.load_mode) begin
                        st        <= ST_LOAD;
                        wr_ptr    <= '0;
                        fault_q   <= 1'b0;
                        overrun_q <= 1'b0;
                    end else if ((prog_len_q != '0) && !fault_q) begin
                        st           <= ST_RUN;
                        core_start_q <= 1'b1;
                        in_snap_q    <= bus.in_pins;
                        timer        <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + (PROG_AW+1)'(1);
                    end
                    // A nibble taken on the closing cycle still counts toward the length.
                    if (!bus.load_mode) begin
                        prog_len_q <= wr_ptr + (PROG_AW+1)'(accept);
                        st         <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    timer <= timer_next;
                    // Priority: load abort, then completion, then watchdog.
                    if (bus.load_mode) begin
                        out_pins_q <= '0;
                        st         <= ST_LOAD;
                        wr_ptr     <= '0;
                        fault_q    <= 1'b0;
                        overrun_q  <= 1'b0;
                    end else if (bus.core_done) begin
                        out_pins_q <= bus.core_out;
                        scan_cnt_q <= scan_cnt_q + 8'd1;
                        if (period_overrun) begin
                            overrun_q <= 1'b1;
                        end
                        st <= ST_WAIT;
                    end else if (wdog_hit) begin
                        fault_q    <= 1'b1;
                        out_pins_q <= '0;
                        st         <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    timer <= timer_next;
                    if (bus.load_mode) begin
                        st        <= ST_LOAD;
                        wr_ptr    <= '0;
                        fault_q   <= 1'b0;
                        overrun_q <= 1'b0;
                    end else if (period_reached) begin
                        st           <= ST_RUN;
                        core_start_q <= 1'b1;
                        in_snap_q    <= bus.in_pins;
                        timer        <= '0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/vslc_scan_ctrl.md
Name: vslc_scan_ctrl

Overview:
Scan-cycle controller for the VSLC stack-machine core.
- Owns program loading into the core's 4-bit code memory through a valid/ready nibble stream.
- Sequences fixed-period PLC scans: snapshot inputs, start the core, wait for completion, commit outputs atomically.
- Supervises each scan with a period-overrun flag and a watchdog; on a watchdog fault, outputs go to a safe state.

Parameters:
PROG_AW, 8, code memory address width; capacity 2^PROG_AW nibbles
TMR_W, 16, width of scan_period and of the scan timer
WDOG_CYC, 1024, maximum RUN cycles before a watchdog fault

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
load_mode  in  1  level; high requests program load
ld_valid  in  1  nibble stream valid
ld_nibble  in  4  nibble stream data
ld_ready  out  1  nibble stream ready
mem_we  out  1  code memory write strobe
mem_addr  out  PROG_AW  code memory write address
mem_wdata  out  4  code memory write data
prog_len  out  PROG_AW+1  number of nibbles loaded
scan_period  in  TMR_W  cycles between scan starts; 0 = free-run
core_start  out  1  one-cycle pulse; core clears pc and stack and begins executing
core_done  in  1  one-cycle pulse; core finished its program
in_pins  in  8  raw field inputs
in_snap  out  8  inputs frozen for the current scan
core_out  in  8  core output image
out_pins  out  8  committed outputs
scan_cnt  out  8  completed scans, wraps at 255->0
overrun  out  1  sticky; a scan finished late
fault  out  1  sticky; watchdog expired
state  out  2  IDLE=0, LOAD=1, RUN=2, WAIT=3

Behaviour:
Reset (rst_n low at a clk edge): state=IDLE. All outputs are 0: ld_ready, mem_we, mem_addr, prog_len, core_start, in_snap, out_pins, scan_cnt, overrun, fault. Reset is honoured in any state.

IDLE:
- load_mode=1 -> LOAD; write pointer cleared to 0; fault and overrun cleared.
- Otherwise, if prog_len!=0 and fault=0 -> RUN.
- Otherwise stay in IDLE.

LOAD:
- ld_ready=1 while the write pointer is below 2^PROG_AW.
- Handshake: mem_we = ld_valid & ld_ready, combinational. mem_addr = pointer. mem_wdata = ld_nibble. Pointer increments on each accepted nibble.
- After 2^PROG_AW accepted nibbles, ld_ready=0 and further nibbles are not accepted.
- load_mode falling -> prog_len <= pointer, then go to IDLE.

RUN:
- First cycle of RUN: core_start=1 (registered, exactly one cycle), in_snap <= in_pins, timer <= 0.
- The timer increments every cycle and saturates at 2^TMR_W-1.
- in_snap is held for the whole scan.
- core_done seen -> out_pins <= core_out, scan_cnt++, go to WAIT.
- On that same core_done edge: if scan_period!=0 and timer >= scan_period, set overrun.
- core_done while not in RUN is ignored.
- Watchdog: timer == WDOG_CYC-1 with no core_done -> fault=1, out_pins <= 0, go to IDLE. No automatic restart until the next load.
- load_mode=1 during RUN aborts the scan: out_pins <= 0, go to LOAD.

WAIT:
- Go to RUN when timer >= scan_period-1, or immediately after one cycle if scan_period=0 or the period is already exceeded.
- Consecutive core_start pulses are therefore exactly scan_period cycles apart when scans finish in time.
- Minimum spacing between core_start pulses is run length + 1 cycle.
- load_mode=1 -> LOAD.

Simultaneous events:
- core_done and watchdog expiry in the same cycle: done wins, no fault.
- load_mode and core_done in the same cycle: load wins, and outputs are not committed.

Output stability: out_pins changes only on a commit, an abort or a fault, never mid-scan.

Test Plan:
- Load 5 nibbles {0,3,1,8,15} with ld_valid held high -> mem_we high 5 cycles, mem_addr 0..4, prog_len=5 after load_mode falls, then core_start pulses one cycle later.
- scan_period=20, core_done returned 6 cycles after each core_start, core_out=0xA5 -> core_start every 20 cycles, out_pins=0xA5 after the first done, scan_cnt increments per scan, overrun=0.
- scan_period=4, core_done 9 cycles after core_start -> overrun=1 sticky, next core_start 2 cycles after done.
- Toggle in_pins every cycle during RUN -> in_snap equals the in_pins value sampled at the core_start edge for the entire scan.
- Never return core_done -> at WDOG_CYC cycles fault=1, out_pins=0, state=IDLE and stays IDLE; a new load clears fault.
- ld_valid with a stalled 2^PROG_AW+3 nibble burst -> exactly 256 writes, ld_ready=0 afterwards, prog_len=256. Assert rst_n low mid-RUN -> all outputs 0 on the next edge.
